// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Data-side memory model for the CPU sram-like port. Requests are accepted with
// req/addr_ok, answered in order with a one-cycle data_ok pulse exactly LATENCY
// cycles after acceptance. At most QDEPTH transactions may be accepted but not
// yet answered. An optional LFSR-driven backpressure gate withholds addr_ok.
//
// Ports
//   clk           clock, all state updates on rising edge
//   resetn        asynchronous active-low reset
//   data_req      request valid
//   data_wr       1 = write, 0 = read
//   data_wen      byte-lane write enables (bit i -> wdata[8i+7:8i])
//   data_addr     byte address, word index taken from [ADDR_WIDTH+1:2]
//   data_wdata    lane-aligned write data
//   bp_en         enable pseudo-random backpressure on addr_ok
//   data_addr_ok  request accepted when data_req & data_addr_ok
//   data_data_ok  response pulse for the oldest outstanding transaction
//   data_rdata    read word, zero unless data_ok of a read
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        bp_en,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(QDEPTH + 1);

    // Fibonacci LFSR, taps 16,14,13,11 expressed in right-shift form
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [31:0]           mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  accept_s;
    logic [15:0]           lfsr_r;
    logic [CW-1:0]         count_r;
    logic [LATENCY-1:0]    pipe_vld_r;
    logic [31:0]           pipe_data_r [LATENCY];
    logic                  unused_addr_s;

    assign idx_s         = data_addr[ADDR_WIDTH+1:2];
    assign unused_addr_s = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

    // No bypass: a retiring entry frees its slot only after its data_ok cycle.
    assign data_addr_ok = resetn & (count_r < CW'(QDEPTH)) & ~(bp_en & lfsr_r[0]);
    assign accept_s     = data_req & data_addr_ok;

    // Responses come straight out of the last pipe stage register.
    assign data_data_ok = pipe_vld_r[LATENCY-1];
    assign data_rdata   = pipe_data_r[LATENCY-1];

    // Backpressure LFSR, free-running whenever out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Outstanding-transaction counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
        end else begin
            case ({accept_s, data_data_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Fixed-latency response pipe; write entries carry zero data so the
    // output register already holds the final rdata value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld_r <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_data_r[k] <= 32'h0;
            end
        end else begin
            pipe_vld_r[0]  <= accept_s;
            pipe_data_r[0] <= (accept_s && !data_wr) ? mem_r[idx_s] : 32'h0;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1];
                pipe_data_r[k] <= pipe_data_r[k-1];
            end
        end
    end

    // Storage array, byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_s && data_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_wen[i]) begin
                    mem_r[idx_s][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
// Directed plus random stimulus against a scoreboard: each accepted request
// pushes its expected response (due cycle, data) to a queue, and every cycle
// the DUT outputs are compared with the queue head. A second instance with
// LATENCY=4, QDEPTH=2 exercises outstanding-limit throttling.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;

    localparam int AW   = 12;
    localparam int LAT  = 2;
    localparam int QD   = 4;
    localparam int LAT2 = 4;
    localparam int QD2  = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req, data_wr, bp_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        req2, wr2, bp2;
    logic [3:0]  wen2;
    logic [31:0] addr2, wdata2;
    logic        addr_ok2, data_ok2;
    logic [31:0] rdata2;

    exp_t        sb_q[$];
    logic [31:0] mdl_mem [4096];
    logic [15:0] lfsr_m;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          retire_pend = 1'b0;
    bit          last_acc, acc2_s;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk(clk), .resetn(resetn), .data_req(data_req), .data_wr(data_wr),
        .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .bp_en(bp_en), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    data_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT2), .QDEPTH(QD2)) dut2 (
        .clk(clk), .resetn(resetn), .data_req(req2), .data_wr(wr2),
        .data_wen(wen2), .data_addr(addr2), .data_wdata(wdata2),
        .bp_en(bp2), .data_addr_ok(addr_ok2), .data_data_ok(data_ok2),
        .data_rdata(rdata2)
    );

    function automatic logic [15:0] lfsr_model(input logic [15:0] l);
        logic [15:0] b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check addr_ok and record accepts before the edge,
    // update the scoreboard and check responses just after it.
    task automatic tick();
        exp_t        e;
        logic        exp_a;
        logic        exp_ok;
        logic [11:0] idx;
        @(negedge clk);
        exp_a = resetn & (sb_q.size() < QD) & ~(bp_en & lfsr_m[0]);
        chk("addr_ok", 32'(data_addr_ok), 32'(exp_a));
        last_acc = data_req & data_addr_ok;
        acc2_s   = req2 & addr_ok2;
        if (last_acc) begin
            idx    = data_addr[13:2];
            e.due  = cyc + LAT;
            e.data = data_wr ? 32'h0 : mdl_mem[idx];
            if (data_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_wen[i]) mdl_mem[idx][8*i +: 8] = data_wdata[8*i +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (resetn) lfsr_m = lfsr_model(lfsr_m);
        if (retire_pend) begin
            void'(sb_q.pop_front());
            retire_pend = 1'b0;
        end
        if (last_acc) sb_q.push_back(e);
        exp_ok = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        chk("data_ok", 32'(data_data_ok), 32'(exp_ok));
        if (exp_ok) begin
            chk("rdata", data_rdata, sb_q[0].data);
            last_rdata  = data_rdata;
            retire_pend = 1'b1;
        end else begin
            chk("rdata_idle", data_rdata, 32'h0);
        end
    endtask

    task automatic issue(input bit wr, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wd);
        data_req   = 1'b1;
        data_wr    = wr;
        data_wen   = wen;
        data_addr  = addr;
        data_wdata = wd;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("accept", 32'(last_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        data_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        data_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0 && !retire_pend) break;
            tick();
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb_q.delete();
        retire_pend = 1'b0;
        lfsr_m = 16'hACE1;
        #1;
        chk("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_data_ok), 32'd0);
        chk("rst_rdata", data_rdata, 32'h0);
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_w, t_r, c0, first_ok, acc_n, acc2_at, third_at;
        logic [31:0] a;
        resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wen = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0; bp_en = 1'b0;
        req2 = 1'b0; wr2 = 1'b0; wen2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0; bp2 = 1'b0;
        lfsr_m = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("reset_data_ok", 32'(data_data_ok), 32'd0);
        chk("reset_rdata", data_rdata, 32'h0);
        resetn = 1'b1;

        // Fill words 0..15 so every later read has a known value
        for (int w = 0; w < 16; w++) issue(1'b1, 4'hF, 32'(w * 4), $urandom());
        drain();

        // Full write then read back; write response carries zero data
        issue(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        drain();
        chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);

        // Single-lane write merges into the existing word
        issue(1'b1, 4'b0100, 32'h0000_0012, 32'h00AA_0000);
        issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        drain();
        chk("t2_merge", last_rdata, 32'hDEAA_BEEF);
        issue(1'b0, 4'h0, 32'h0000_0013, 32'h0);
        drain();
        chk("t2_low_bits_ignored", last_rdata, 32'hDEAA_BEEF);

        // Read in the cycle right after the write sees the new data
        issue(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678);
        t_w = cyc;
        issue(1'b0, 4'h0, 32'h0000_0020, 32'h0);
        t_r = cyc;
        drain();
        chk("t3_b2b_accept", 32'(t_r - t_w), 32'd1);
        chk("t3_rdata", last_rdata, 32'h1234_5678);

        // Upper address bits alias onto the same word
        issue(1'b0, 4'h0, 32'hA5A5_0010, 32'h0);
        drain();
        chk("alias_rdata", last_rdata, 32'hDEAA_BEEF);

        // Zero-enable write is a no-op but still answered
        issue(1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF);
        issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        drain();
        chk("wen0_noop", last_rdata, 32'hDEAA_BEEF);

        // Eight back-to-back reads must be accepted one per cycle
        c0 = cyc;
        for (int w = 0; w < 8; w++) issue(1'b0, 4'h0, 32'(w * 4), 32'h0);
        chk("t4_b2b_8", 32'(cyc - c0), 32'd8);
        drain();

        // Small instance: third request held off until after first data_ok
        req2 = 1'b1;
        c0 = cyc; first_ok = -1; acc_n = 0; acc2_at = -1; third_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_ok2 && first_ok < 0) first_ok = cyc - c0;
            if (acc2_s) begin
                acc_n++;
                if (acc_n == 2) acc2_at = cyc - 1 - c0;
                if (acc_n == 3) begin
                    third_at = cyc - 1 - c0;
                    req2 = 1'b0;
                    break;
                end
            end
        end
        req2 = 1'b0;
        chk("t4q_second_accept", 32'(acc2_at), 32'd1);
        chk("t4q_first_data_ok", 32'(first_ok), 32'(LAT2));
        chk("t4q_third_accept", 32'(third_at), 32'(LAT2 + 1));
        idle(8);

        // Reset with reads in flight drops them; array keeps its data
        issue(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        issue(1'b0, 4'h0, 32'h0000_0020, 32'h0);
        do_reset();
        idle(6);
        issue(1'b0, 4'h0, 32'h0000_0020, 32'h0);
        drain();
        chk("t5_data_kept", last_rdata, 32'h1234_5678);

        // Random traffic under backpressure
        bp_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            a = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 15) * 4)
                | 32'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        bp_en = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
